// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage initiator for data_mem.
// Accepts load/store requests over a valid/ready handshake, drives the memory's
// r/w/addr/data_in, hides its 1-cycle registered read latency, and returns load
// data (or a store acknowledge) over a valid/ready response channel.
// Loads may be bursts of up to 2**LEN_W consecutive words; stores are single-word.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge where
// valid and ready are both high. A valid holder keeps valid and its payload stable
// until that edge. req_ready is high only in IDLE, so a new request can never be
// accepted on the same edge that completes a response beat.

module mem_req_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              busy,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [LEN_W-1:0]    r_beats_left;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_last;
    logic                w_issue;

    // Request/response FSM: one memory access per beat, response held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_beats_left <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // req_ready comes up on the first edge after reset release.
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_we         <= req_we;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_beats_left <= req_we ? '0 : req_len;
                        r_req_ready  <= 1'b0;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        // Store acknowledge: write lands on this edge, respond now.
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_last  <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Read data from the memory is valid during this cycle only.
                    r_rsp_rdata <= mem_rdata;
                    r_rsp_last  <= (r_beats_left == '0);
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_req_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            // Wraps modulo 2**ADDR_W at the top of the address space.
                            r_addr       <= r_addr + 1'b1;
                            r_beats_left <= r_beats_left - 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory strobes decode from state so they drop the instant reset asserts.
    always_comb begin
        w_issue   = (r_state == S_ISSUE);
        mem_r     = w_issue && !r_we;
        mem_w     = w_issue && r_we;
        mem_addr  = w_issue ? r_addr : '0;
        mem_wdata = mem_w ? r_wdata : '0;
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_last    = r_rsp_last;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: a data_mem model with 1-cycle registered read,
// directed request vectors with hand-computed responses, and two monitors that
// pop expected memory accesses and response beats from scoreboard queues.

module tb_mem_req_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;
    // Read port output when no read was issued the cycle before.
    localparam logic [DATA_W-1:0] STALE = 32'h0BAD_F00D;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic              busy;
    logic              mem_r;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    // {last, rdata}
    logic [DATA_W:0]          exp_rsp_q[$];
    // {we, addr, wdata}
    logic [ADDR_W+DATA_W:0]   exp_mem_q[$];
    logic [DATA_W:0]          e_rsp;
    logic [ADDR_W+DATA_W:0]   e_mem;

    logic [DATA_W-1:0] dmem [256];

    mem_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_len     (req_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_last    (rsp_last),
        .busy        (busy),
        .mem_r       (mem_r),
        .mem_w       (mem_w),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    // data_mem model: only the used addresses matter, so the low 8 bits index it
    // (0xFFFFFFFF lands on entry 255, which nothing else uses).
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
            dmem[0] <= 32'd55;
            dmem[2] <= 32'd31;
            dmem[3] <= 32'd1024;
            dmem[4] <= 32'd9;
            dmem[5] <= 32'd2048;
            dmem[6] <= 32'd10;
            mem_rdata <= STALE;
        end else begin
            if (mem_w) dmem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem_r ? dmem[mem_addr[7:0]] : STALE;
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_rsp(input logic last, input logic [DATA_W-1:0] data);
        exp_rsp_q.push_back({last, data});
    endfunction

    function automatic void push_mem(input logic we, input logic [ADDR_W-1:0] addr,
                                     input logic [DATA_W-1:0] wdata);
        exp_mem_q.push_back({we, addr, wdata});
    endfunction

    // Response monitor: a beat transfers on the next edge when valid&&ready at negedge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
                chk("rsp_unexpected_beat", {32'd0, rsp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e_rsp = exp_rsp_q.pop_front();
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e_rsp[DATA_W-1:0]});
                chk("rsp_last", {63'd0, rsp_last}, {63'd0, e_rsp[DATA_W]});
            end
        end
    end

    // Memory monitor: every strobe cycle must match the next expected access.
    always @(negedge clk) begin
        if (mem_r || mem_w) begin
            chk("mem_r_and_mem_w", {62'd0, mem_r, mem_w}, {62'd0, ~mem_w, mem_w});
            if (exp_mem_q.size() == 0) begin
                chk("mem_unexpected_access", {31'd0, mem_w, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e_mem = exp_mem_q.pop_front();
                chk("mem_we", {63'd0, mem_w}, {63'd0, e_mem[ADDR_W+DATA_W]});
                chk("mem_addr", {32'd0, mem_addr}, {32'd0, e_mem[ADDR_W+DATA_W-1:DATA_W]});
                if (mem_w) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_mem[DATA_W-1:0]});
            end
        end
    end

    // Driver: present a request once req_ready is seen, returns 1ns after the accept edge.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [LEN_W-1:0] len);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
        end else begin
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = addr;
            req_wdata = wdata;
            req_len   = len;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_we    = 1'b0;
            req_addr  = '0;
            req_wdata = '0;
            req_len   = '0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || exp_rsp_q.size() != 0 || exp_mem_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_rsp_data(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!(rsp_valid && rsp_rdata == d) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_rsp_timeout", {63'd0, rsp_valid}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_rsp_last", {63'd0, rsp_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_strobes", {62'd0, mem_r, mem_w}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready_after_release", {63'd0, req_ready}, 64'd1);

        // 1: single load, response two cycles after accept
        push_mem(1'b0, 32'd0, 32'd0);
        push_rsp(1'b1, 32'd55);
        do_req(1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_req_ready_busy", {63'd0, req_ready}, 64'd0);
        chk("t1_valid_e0", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("t1_valid_e1", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("t1_valid_e2", {63'd0, rsp_valid}, 64'd1);
        wait_done();

        // 2: five-beat burst from address 2
        for (int a = 2; a <= 6; a++) push_mem(1'b0, 32'(a), 32'd0);
        push_rsp(1'b0, 32'd31);
        push_rsp(1'b0, 32'd1024);
        push_rsp(1'b0, 32'd9);
        push_rsp(1'b0, 32'd2048);
        push_rsp(1'b1, 32'd10);
        do_req(1'b0, 32'd2, 32'hFFFF_FFFF, 3'd4);
        wait_done();

        // 3: store then read back
        push_mem(1'b1, 32'd100, 32'h0000_DEAD);
        push_rsp(1'b1, 32'd0);
        do_req(1'b1, 32'd100, 32'h0000_DEAD, 3'd5);
        @(negedge clk);
        chk("t3_mem_w_e0", {63'd0, mem_w}, 64'd1);
        chk("t3_valid_e0", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("t3_mem_w_e1", {63'd0, mem_w}, 64'd0);
        chk("t3_valid_e1", {63'd0, rsp_valid}, 64'd1);
        wait_done();
        push_mem(1'b0, 32'd100, 32'd0);
        push_rsp(1'b1, 32'h0000_DEAD);
        do_req(1'b0, 32'd100, 32'd0, 3'd0);
        wait_done();

        // 4: stall the consumer on beat 2 of a three-beat burst
        for (int a = 2; a <= 4; a++) push_mem(1'b0, 32'(a), 32'd0);
        push_rsp(1'b0, 32'd31);
        push_rsp(1'b0, 32'd1024);
        push_rsp(1'b1, 32'd9);
        do_req(1'b0, 32'd2, 32'd0, 3'd2);
        wait_rsp_data(32'd1024);
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t4_stall_valid", {63'd0, rsp_valid}, 64'd1);
            chk("t4_stall_rdata", {32'd0, rsp_rdata}, 64'd1024);
            chk("t4_stall_last", {63'd0, rsp_last}, 64'd0);
            chk("t4_stall_no_mem_r", {63'd0, mem_r}, 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_done();

        // 5: reset during the third beat's memory read of a five-beat burst
        push_mem(1'b0, 32'd2, 32'd0);
        push_mem(1'b0, 32'd3, 32'd0);
        push_rsp(1'b0, 32'd31);
        push_rsp(1'b0, 32'd1024);
        do_req(1'b0, 32'd2, 32'd0, 3'd4);
        begin
            int n;
            n = 0;
            while (!(mem_r && mem_addr == 32'd4) && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("t5_reach_beat3", {63'd0, mem_r}, 64'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mem_r", {63'd0, mem_r}, 64'd0);
        chk("t5_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_req_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rsp_q_drained", 64'(exp_rsp_q.size()), 64'd0);
        chk("t5_mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
        push_mem(1'b0, 32'd0, 32'd0);
        push_rsp(1'b1, 32'd55);
        do_req(1'b0, 32'd0, 32'd0, 3'd0);
        wait_done();

        // 6: address wrap at the top of the address space
        push_mem(1'b1, 32'hFFFF_FFFF, 32'd7);
        push_rsp(1'b1, 32'd0);
        do_req(1'b1, 32'hFFFF_FFFF, 32'd7, 3'd0);
        wait_done();
        push_mem(1'b0, 32'hFFFF_FFFF, 32'd0);
        push_mem(1'b0, 32'h0000_0000, 32'd0);
        push_rsp(1'b0, 32'd7);
        push_rsp(1'b1, 32'd55);
        do_req(1'b0, 32'hFFFF_FFFF, 32'd0, 3'd1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("end_rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
        chk("end_mem_q_empty", 64'(exp_mem_q.size()), 64'd0);
        chk("end_idle", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
